regfile_writeback_ctrl: RTL and testbench

- Write-side master for the RegisterFile write port: generates write_reg / regWrite / writeData.
- After reset, it sequences a zero-fill of all 32 registers.
- It then merges results from the ALU and memory/load paths through a small in-order FIFO, one register write per cycle.
- It also exposes a forwarding query over writes that are queued but not yet committed, so decode can read the newest pending value.

---
 rtl/regfile_writeback_ctrl.sv | 171 +++++++++++++++++
 tb/tb_regfile_writeback_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_ctrl.sv
// Write-side master for the register file: zero-fills all registers after reset,
// then drains a small in-order FIFO of ALU/load results, one write per cycle.
// Also answers forwarding queries over queued and in-flight writes.
module regfile_writeback_ctrl #(
  parameter int DEPTH    = 4,
  parameter int NUM_REGS = 32,
  parameter int DROP_R0  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        hold,
  output logic [4:0]  write_reg,
  output logic        regWrite,
  output logic [31:0] writeData,
  input  logic [4:0]  query_reg,
  output logic        query_hit,
  output logic [31:0] query_data,
  output logic        init_done,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [4:0]   r_cnt;
  logic         r_init_done;
  logic         r_reg_write;
  logic [4:0]   r_write_reg;
  logic [31:0]  r_write_data;

  logic [4:0]   r_fifo_rd   [DEPTH];
  logic [31:0]  r_fifo_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic         w_in_init;
  logic         w_init_last;
  logic         w_full;
  logic         w_empty;
  logic         w_mem_acc;
  logic         w_alu_acc;
  logic [4:0]   w_acc_rd;
  logic [31:0]  w_acc_data;
  logic         w_push;
  logic         w_pop;
  logic         w_query_hit;
  logic [31:0]  w_query_data;
  logic [PW-1:0] w_idx;

  // State register: INIT restarts on every reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  // Next state: leave INIT after the last zero-fill write is issued.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && w_init_last) w_state_nxt = S_RUN;
  end

  // Control decodes: accept/issue handshakes; mem results win over ALU results.
  always_comb begin
    w_in_init   = (r_state == S_INIT);
    w_init_last = (r_cnt == 5'(NUM_REGS - 1));
    w_full      = (r_count == CW'(DEPTH));
    w_empty     = (r_count == '0);
    mem_ready   = r_init_done && !w_full;
    alu_ready   = r_init_done && !w_full && !mem_valid;
    w_mem_acc   = mem_valid && mem_ready;
    w_alu_acc   = alu_valid && alu_ready;
    w_acc_rd    = w_mem_acc ? mem_rd   : alu_rd;
    w_acc_data  = w_mem_acc ? mem_data : alu_data;
    // Writes to r0 finish their handshake but never reach the FIFO.
    w_push      = (w_mem_acc || w_alu_acc) && !((DROP_R0 != 0) && (w_acc_rd == 5'd0));
    w_pop       = (r_state == S_RUN) && !hold && !w_empty;
  end

  // Zero-fill address counter, only advances during INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_cnt <= '0;
    else if (w_in_init) r_cnt <= r_cnt + 5'd1;
  end

  // init_done rises on the same edge as the final zero-fill write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          r_init_done <= 1'b0;
    else if (w_in_init && w_init_last)  r_init_done <= 1'b1;
  end

  // Registered write port: zero-fill in INIT, FIFO head in RUN; address/data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (w_in_init) begin
      r_reg_write  <= 1'b1;
      r_write_reg  <= r_cnt;
      r_write_data <= '0;
    end else if (w_pop) begin
      r_reg_write  <= 1'b1;
      r_write_reg  <= r_fifo_rd[r_rptr];
      r_write_data <= r_fifo_data[r_rptr];
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= w_acc_rd;
      r_fifo_data[r_wptr] <= w_acc_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Forwarding: scan oldest to youngest (in-flight write, then head..tail) so the last match wins.
  always_comb begin
    w_query_hit  = 1'b0;
    w_query_data = '0;
    w_idx        = '0;
    if (r_reg_write && r_write_reg == query_reg) begin
      w_query_hit  = 1'b1;
      w_query_data = r_write_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PW'(i);
      if (CW'(i) < r_count && r_fifo_rd[w_idx] == query_reg) begin
        w_query_hit  = 1'b1;
        w_query_data = r_fifo_data[w_idx];
      end
    end
  end

  assign write_reg  = r_write_reg;
  assign regWrite   = r_reg_write;
  assign writeData  = r_write_data;
  assign init_done  = r_init_done;
  assign query_hit  = w_query_hit;
  assign query_data = w_query_data;
  assign busy       = (r_state == S_INIT) || !w_empty || r_reg_write;

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Bench for regfile_writeback_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model of the write path.
module tb_regfile_writeback_ctrl;

  localparam int DEPTH    = 4;
  localparam int NUM_REGS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, hold;
  logic [4:0]  alu_rd, mem_rd, query_reg;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, regWrite, query_hit, init_done, busy;
  logic [4:0]  write_reg;
  logic [31:0] writeData, query_data;

  regfile_writeback_ctrl #(.DEPTH(DEPTH), .NUM_REGS(NUM_REGS), .DROP_R0(1)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .hold(hold), .write_reg(write_reg), .regWrite(regWrite), .writeData(writeData),
    .query_reg(query_reg), .query_hit(query_hit), .query_data(query_data),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: pending writes as a queue of {rd, data}, plus the visible write port.
  bit          m_init, m_done, m_rw;
  int          m_cnt;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  logic [36:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_init = 1; m_done = 0; m_rw = 0; m_cnt = 0; m_wr = '0; m_wd = '0;
    m_q.delete();
  endtask

  // Youngest pending write wins; the write on the port counts only if nothing queued matches.
  task automatic model_fwd(input logic [4:0] q, output logic h, output logic [31:0] d);
    h = 0; d = '0;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i][36:32] == q) begin h = 1; d = m_q[i][31:0]; return; end
    end
    if (m_rw && m_wr == q) begin h = 1; d = m_wd; end
  endtask

  task automatic check_outputs(input logic mv, input logic [4:0] q);
    logic        rdy, eh;
    logic [31:0] ed;
    rdy = m_done && (m_q.size() < DEPTH);
    model_fwd(q, eh, ed);
    chk("mem_ready",  mem_ready,  rdy);
    chk("alu_ready",  alu_ready,  rdy && !mv);
    chk("regWrite",   regWrite,   m_rw);
    chk("write_reg",  write_reg,  m_wr);
    chk("writeData",  writeData,  m_wd);
    chk("init_done",  init_done,  m_done);
    chk("busy",       busy,       m_init || (m_q.size() > 0) || m_rw);
    chk("query_hit",  query_hit,  eh);
    chk("query_data", query_data, ed);
  endtask

  // One clock cycle: drive at negedge, check, advance the model across the rising edge.
  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic h, input logic [4:0] q);
    logic        rdy, ma, aa;
    logic [36:0] e;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    hold = h; query_reg = q;
    #1;
    check_outputs(mv, q);
    rdy = m_done && (m_q.size() < DEPTH);
    ma  = mv && rdy;
    aa  = av && rdy && !mv;
    @(posedge clk);
    if (m_init) begin
      m_rw = 1; m_wr = m_cnt[4:0]; m_wd = '0;
      if (m_cnt == NUM_REGS - 1) begin m_init = 0; m_done = 1; end
      m_cnt++;
    end else begin
      if (!h && m_q.size() > 0) begin
        e = m_q.pop_front();
        m_rw = 1; m_wr = e[36:32]; m_wd = e[31:0];
      end else begin
        m_rw = 0;
      end
      if (ma && mr != 0)      m_q.push_back({mr, md});
      else if (aa && ar != 0) m_q.push_back({ar, ad});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic h, input logic [4:0] q);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, h, q);
  endtask

  task automatic alu(input logic [4:0] r, input logic [31:0] d, input logic h, input logic [4:0] q);
    cycle(1, r, d, 0, 5'd0, 32'd0, h, q);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; alu_valid = 0; mem_valid = 0; hold = 0;
    alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0; query_reg = '0;
    model_reset();

    // Reset for three cycles, then the 32-write zero-fill and the drop of busy.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs(0, 5'd0);
    reset = 0;
    for (int i = 0; i < NUM_REGS + 2; i++) idle(0, 5'(i));
    chk("init_done_after_fill", init_done, 1);

    // Single ALU write shows up one cycle after acceptance.
    alu(5'd7, 32'd24, 0, 5'd7);
    repeat (3) idle(0, 5'd7);

    // mem and ALU together: mem first, ALU accepted next cycle.
    cycle(1, 5'd5, 32'h5, 1, 5'd3, 32'hDEADBEEF, 0, 5'd3);
    cycle(1, 5'd5, 32'h5, 0, 5'd0, 32'd0, 0, 5'd5);
    repeat (3) idle(0, 5'd5);

    // Fill under hold, attempt a fifth push while full, then drain.
    alu(5'd1, 32'h11, 1, 5'd1);
    alu(5'd2, 32'h22, 1, 5'd2);
    alu(5'd3, 32'h33, 1, 5'd3);
    alu(5'd4, 32'h44, 1, 5'd4);
    alu(5'd6, 32'h66, 1, 5'd6);
    idle(1, 5'd4);
    alu(5'd6, 32'h66, 0, 5'd6);
    repeat (6) idle(0, 5'd6);

    // Forwarding returns the youngest value; r0 writes are dropped.
    alu(5'd9, 32'd1, 1, 5'd9);
    alu(5'd9, 32'd2, 1, 5'd9);
    idle(1, 5'd9);
    idle(1, 5'd10);
    alu(5'd0, 32'hABCD, 1, 5'd0);
    idle(1, 5'd0);
    repeat (4) idle(0, 5'd9);

    // Mid-cycle reset with entries queued: outputs clear at once, INIT restarts.
    alu(5'd12, 32'hC1, 1, 5'd12);
    alu(5'd13, 32'hC2, 1, 5'd13);
    alu(5'd14, 32'hC3, 1, 5'd14);
    #2 reset = 1;
    #1;
    chk("rst_regWrite",  regWrite,  0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_writeData", writeData, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_mem_ready", mem_ready, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < NUM_REGS + 4; i++) idle(0, 5'd12 + 5'(i % 3));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)));
    end
    repeat (8) idle(0, 5'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
